// File: rtl/tile_sequencer.sv
// Frame sequencer: walks NB_TILES tiles, fetching COEFF_WORDS coefficients per tile over a
// wishbone master and then running the init / cache-fill / incremental-compute handshakes.
module tile_sequencer #(
    parameter int unsigned NB_TILES    = 1200,
    parameter int unsigned COEFF_WORDS = 4,
    parameter int unsigned TILE_W      = 11,
    localparam int unsigned IDX_W      = (COEFF_WORDS > 1) ? $clog2(COEFF_WORDS) : 1
) (
    input  logic              clk,
    input  logic              preset_n,
    input  logic [31:0]       wb_reg_data,
    input  logic [31:0]       wb_reg_ctr,
    output logic              p_interrupt,
    output logic              p_busy,
    output logic              p_wb_STB_O,
    output logic              p_wb_CYC_O,
    output logic              p_wb_LOCK_O,
    output logic [3:0]        p_wb_SEL_O,
    output logic              p_wb_WE_O,
    output logic [31:0]       p_wb_ADR_O,
    input  logic              p_wb_ACK_I,
    input  logic [31:0]       p_wb_DAT_I,
    output logic [31:0]       p_wb_DAT_O,
    output logic [31:0]       coeff_data,
    output logic [IDX_W-1:0]  coeff_idx,
    output logic              coeff_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              init_start,
    input  logic              init_done,
    output logic              fill_req,
    input  logic              cache_rdy,
    output logic              incr_start,
    input  logic              incr_done
);

    localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(COEFF_WORDS - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NB_TILES - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StInit, StFill, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic              old0_q, old1_q;
    logic [31:0]       base_q, base_d;
    logic              single_q, single_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic              stb_q, stb_d;
    logic              abort_pend_q, abort_pend_d;
    logic [31:0]       coeff_data_q, coeff_data_d;
    logic [IDX_W-1:0]  coeff_idx_q, coeff_idx_d;
    logic              coeff_valid_q, coeff_valid_d;
    logic              init_start_q, init_start_d;
    logic              fill_req_q, fill_req_d;
    logic              incr_start_q, incr_start_d;
    logic              irq_q, irq_d;

    logic        start_ev, ack_ev, abort;
    logic        cyc;
    logic [31:0] word_off;
    logic        unused_ctr;

    assign start_ev   = wb_reg_ctr[0] & ~old0_q;
    assign ack_ev     = wb_reg_ctr[1] & ~old1_q;
    assign abort      = wb_reg_ctr[2];
    assign unused_ctr = ^wb_reg_ctr[31:4];

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        single_d      = single_q;
        tile_d        = tile_q;
        k_d           = k_q;
        stb_d         = stb_q;
        abort_pend_d  = abort_pend_q;
        coeff_data_d  = coeff_data_q;
        coeff_idx_d   = coeff_idx_q;
        coeff_valid_d = 1'b0;
        init_start_d  = 1'b0;
        fill_req_d    = 1'b0;
        incr_start_d  = 1'b0;
        irq_d         = irq_q & ~ack_ev;

        case (state_q)
            StIdle: begin
                if (start_ev && !abort) begin
                    state_d      = StFetch;
                    base_d       = wb_reg_data;
                    single_d     = wb_reg_ctr[3];
                    tile_d       = '0;
                    k_d          = '0;
                    stb_d        = 1'b1;
                    abort_pend_d = 1'b0;
                end
            end
            StFetch: begin
                if (stb_q) begin
                    // An abort seen mid-transfer is remembered so the read still completes.
                    if (abort) abort_pend_d = 1'b1;
                    if (p_wb_ACK_I) begin
                        stb_d = 1'b0;
                        if (abort || abort_pend_q) begin
                            state_d      = StIdle;
                            abort_pend_d = 1'b0;
                        end else begin
                            coeff_data_d  = p_wb_DAT_I;
                            coeff_idx_d   = k_q;
                            coeff_valid_d = 1'b1;
                            if (k_q == K_LAST) begin
                                state_d      = StInit;
                                init_start_d = 1'b1;
                            end else begin
                                k_d = k_q + 1'b1;
                            end
                        end
                    end
                end else if (abort) begin
                    state_d = StIdle;
                end else begin
                    stb_d = 1'b1;
                end
            end
            StInit: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (init_done) begin
                    state_d    = StFill;
                    fill_req_d = 1'b1;
                end
            end
            StFill: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cache_rdy) begin
                    state_d      = StCalc;
                    incr_start_d = 1'b1;
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (incr_done) begin
                    if (tile_q == TILE_LAST || single_q) begin
                        state_d = StDone;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = StFetch;
                        tile_d  = tile_q + 1'b1;
                        k_d     = '0;
                        stb_d   = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= StIdle;
            old0_q        <= 1'b0;
            old1_q        <= 1'b0;
            base_q        <= '0;
            single_q      <= 1'b0;
            tile_q        <= '0;
            k_q           <= '0;
            stb_q         <= 1'b0;
            abort_pend_q  <= 1'b0;
            coeff_data_q  <= '0;
            coeff_idx_q   <= '0;
            coeff_valid_q <= 1'b0;
            init_start_q  <= 1'b0;
            fill_req_q    <= 1'b0;
            incr_start_q  <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            old0_q        <= wb_reg_ctr[0];
            old1_q        <= wb_reg_ctr[1];
            base_q        <= base_d;
            single_q      <= single_d;
            tile_q        <= tile_d;
            k_q           <= k_d;
            stb_q         <= stb_d;
            abort_pend_q  <= abort_pend_d;
            coeff_data_q  <= coeff_data_d;
            coeff_idx_q   <= coeff_idx_d;
            coeff_valid_q <= coeff_valid_d;
            init_start_q  <= init_start_d;
            fill_req_q    <= fill_req_d;
            incr_start_q  <= incr_start_d;
            irq_q         <= irq_d;
        end
    end

    // Bus cycle is tied to the state register so reset drops CYC asynchronously.
    assign cyc      = (state_q == StFetch);
    assign word_off = 32'(tile_q) * COEFF_WORDS + 32'(k_q);

    assign p_busy      = (state_q != StIdle);
    assign p_interrupt = irq_q;
    assign p_wb_CYC_O  = cyc;
    assign p_wb_LOCK_O = cyc;
    assign p_wb_STB_O  = cyc & stb_q;
    assign p_wb_SEL_O  = {4{cyc}};
    assign p_wb_WE_O   = 1'b0;
    assign p_wb_DAT_O  = '0;
    assign p_wb_ADR_O  = cyc ? (base_q + {word_off[29:0], 2'b00}) : '0;
    assign coeff_data  = coeff_data_q;
    assign coeff_idx   = coeff_idx_q;
    assign coeff_valid = coeff_valid_q;
    assign tile_idx    = tile_q;
    assign init_start  = init_start_q;
    assign fill_req    = fill_req_q;
    assign incr_start  = incr_start_q;

endmodule
